// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: widths, PC step, reset PC, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_defs;

  localparam int          INSTR_W       = 32;
  localparam int          PC_STEP       = 4;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam int          FQ_DEPTH      = 2;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Fetch-queue entry layout, MSB first: {pc, instr}.
  // The instruction occupies the low INSTR_W bits, the PC the bits above it.
  localparam int FQ_INSTR_LSB = 0;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr} with flush; head is read combinationally.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: caller must never push when full; flush wins over push/pop.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_pc,
  input  logic [INSTR_W-1:0]  push_instr,
  input  logic                pop,
  input  logic                flush,
  output logic [1:0]          count,
  output logic [ADDR_W-1:0]   head_pc,
  output logic [INSTR_W-1:0]  head_instr,
  output logic                head_valid
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ENTRY_W-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;

  // Storage, pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_pc, push_instr};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_instr = mem[rd_ptr][FQ_INSTR_LSB +: INSTR_W];
  assign head_pc    = mem[rd_ptr][INSTR_W +: ADDR_W];
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues req/gnt/rvalid reads, buffers words in a 2-entry queue.
// Latency: 3 cycles from idle to first valid instruction; 1 instruction per 2 cycles max.
// Backpressure: stall holds the head; new requests stop once queue + outstanding reach 2.
module instr_fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DFLT),
  parameter int                DEPTH    = FQ_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_en,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic [INSTR_W-1:0]  instruction,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid
);

  localparam logic [1:0]        DEPTH_C = 2'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic              drop, drop_nxt;
  logic [1:0]        fq_count;
  logic              push, pop;
  logic              room_after_push;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // A response is only kept when it belongs to a live request and no redirect is in flight
  assign push = (state == ST_WAIT) && imem_rvalid && !drop && !redirect_en;
  assign pop  = instr_valid && !stall && !redirect_en;

  // In WAIT the single outstanding request retires with this push
  assign room_after_push = ({1'b0, fq_count} + 3'd1) < {1'b0, DEPTH_C};

  // Next-state logic: normal fetch flow first, redirect overrides afterwards
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    drop_nxt     = drop;
    case (state)
      ST_IDLE: if (fq_count < DEPTH_C) state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          state_nxt    = ST_WAIT;
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + PC_INC;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          drop_nxt  = 1'b0;
          state_nxt = (drop || room_after_push) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (redirect_en) begin
      fetch_pc_nxt = redirect_aligned;
      case (state)
        ST_IDLE: state_nxt = ST_REQ;
        // Granted this cycle: that response belongs to the old path
        ST_REQ:  if (imem_gnt) drop_nxt = 1'b1;
        ST_WAIT: begin
          if (imem_rvalid) begin
            // The stale response arrives right now; nothing left to discard
            drop_nxt  = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM, PC and drop-flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      drop     <= drop_nxt;
    end
  end

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = fetch_pc;

  fetch_queue #(
    .ADDR_W (ADDR_W)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (req_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect_en),
    .count      (fq_count),
    .head_pc    (instr_pc),
    .head_instr (instruction),
    .head_valid (instr_valid)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written sequences.
// Latency: n/a.
// Backpressure: memory responder grants immediately and answers one cycle later in auto mode.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int passed = 0;
  int total  = 0;
  logic auto_mem = 1'b0;
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rvalid, stall, redir;
    logic [31:0] rdata, rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, instr;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic st, input logic rd,
                              input logic [31:0] dat, input logic [31:0] rpc,
                              input logic rq, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t r;
    r.gnt = g; r.rvalid = rv; r.stall = st; r.redir = rd; r.rdata = dat; r.rpc = rpc;
    r.req = rq; r.addr = ad; r.valid = v; r.pc = p; r.instr = ins;
    return r;
  endfunction

  function automatic logic [31:0] mem_dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock: log deliveries, advance, then let the auto responder drive the next cycle
  task automatic tick();
    logic        g;
    logic [31:0] ga;
    g  = auto_mem && imem_req && imem_gnt;
    ga = imem_addr;
    if (rst && instr_valid && !stall && !redirect_en) begin
      got_pc.push_back(instr_pc);
      got_in.push_back(instruction);
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_gnt    = 1'b1;
      imem_rvalid = g;
      imem_rdata  = g ? mem_dat(ga) : 32'h0;
    end
  endtask

  task automatic set_in(input logic g, input logic rv, input logic [31:0] dat,
                        input logic rd, input logic [31:0] rpc);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = dat; redirect_en = rd; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    auto_mem = 1'b0;
    stall = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("reset_outputs", {28'h0, imem_req, instr_valid, |imem_addr, |(instruction | instr_pc)}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    got_pc.delete();
    got_in.delete();
  endtask

  vec_t tbl[13];

  initial begin
    logic ok;
    logic prev_v;
    logic bad_alt;
    logic bad_al;
    rst = 1'b0;
    stall = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;

    // ---- table: per-cycle manual handshake ----
    //            gnt rv  st  rd  rdata          rpc           req addr           v  pc            instr
    tbl[0]  = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h0,         0, 32'h0,   32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,         32'h0,        0, 32'h4,         0, 32'h0,   32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 32'hAAAA_0000, 32'h0,        1, 32'h4,         1, 32'h0,   32'hAAAA_0000);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0,         32'h0,        0, 32'h8,         0, 32'h0,   32'h0);
    tbl[4]  = mk(0, 1, 1, 0, 32'hBBBB_0004, 32'h0,        1, 32'h8,         1, 32'h4,   32'hBBBB_0004);
    tbl[5]  = mk(1, 0, 1, 0, 32'h0,         32'h0,        0, 32'hC,         1, 32'h4,   32'hBBBB_0004);
    tbl[6]  = mk(0, 1, 0, 0, 32'hCCCC_0008, 32'h0,        0, 32'hC,         1, 32'h8,   32'hCCCC_0008);
    tbl[7]  = mk(0, 1, 1, 0, 32'hDEAD_0000, 32'h0,        1, 32'hC,         1, 32'h8,   32'hCCCC_0008);
    tbl[8]  = mk(0, 0, 1, 0, 32'h0,         32'h0,        1, 32'hC,         1, 32'h8,   32'hCCCC_0008);
    tbl[9]  = mk(0, 0, 0, 1, 32'h0,         32'h203,      1, 32'h200,       0, 32'h0,   32'h0);
    tbl[10] = mk(1, 0, 0, 0, 32'h0,         32'h0,        0, 32'h204,       0, 32'h0,   32'h0);
    tbl[11] = mk(0, 1, 0, 0, 32'h5555_0200, 32'h0,        1, 32'h204,       1, 32'h200, 32'h5555_0200);
    tbl[12] = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h204,       0, 32'h0,   32'h0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].redir, tbl[i].rpc);
      stall = tbl[i].stall;
      tick();
      ok = (imem_req === tbl[i].req) && (imem_addr === tbl[i].addr) && (instr_valid === tbl[i].valid);
      if (tbl[i].valid) ok = ok && (instr_pc === tbl[i].pc) && (instruction === tbl[i].instr);
      total++;
      if (ok) passed++;
      else $display("FAIL vec%0d: got req=%b addr=%h v=%b pc=%h ins=%h expected req=%b addr=%h v=%b pc=%h ins=%h",
                    i, imem_req, imem_addr, instr_valid, instr_pc, instruction,
                    tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc, tbl[i].instr);
    end

    // ---- zero-wait stream ----
    do_reset();
    auto_mem = 1'b1; imem_gnt = 1'b1;
    prev_v = 1'b0; bad_alt = 1'b0; bad_al = 1'b0;
    for (int n = 0; n < 20 && got_pc.size() < 4; n++) begin
      tick();
      if (instr_valid && prev_v) bad_alt = 1'b1;
      if (imem_addr[1:0] != 2'b00) bad_al = 1'b1;
      prev_v = instr_valid;
    end
    chk("stream_count", got_pc.size(), 32'd4);
    for (int k = 0; k < 4 && k < got_pc.size(); k++) begin
      chk($sformatf("stream_pc%0d", k), got_pc[k], 32'(4 * k));
      chk($sformatf("stream_ins%0d", k), got_in[k], mem_dat(32'(4 * k)));
    end
    chk("stream_alternate", {31'h0, bad_alt}, 32'h0);
    chk("stream_aligned", {31'h0, bad_al}, 32'h0);

    // ---- stall fills queue, then drains in order ----
    do_reset();
    stall = 1'b1; auto_mem = 1'b1; imem_gnt = 1'b1;
    ok = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (n >= 2 && !(instr_valid && instr_pc == 32'h0)) ok = 1'b0;
    end
    chk("stall_head_stable", {31'h0, ok}, 32'h1);
    chk("stall_req_dropped", {31'h0, imem_req}, 32'h0);
    chk("stall_head_ins", instruction, mem_dat(32'h0));
    got_pc.delete(); got_in.delete();
    stall = 1'b0;
    for (int n = 0; n < 30 && got_pc.size() < 3; n++) tick();
    chk("drain_count", got_pc.size(), 32'd3);
    for (int k = 0; k < 3 && k < got_pc.size(); k++)
      chk($sformatf("drain_pc%0d", k), got_pc[k], 32'(4 * k));

    // ---- gnt withheld; rvalid outside WAIT ignored ----
    do_reset();
    set_in(1'b0, 1'b1, 32'hBAD0_0000, 1'b0, 32'h0);
    tick();
    chk("idle_rvalid_ignored", {31'h0, instr_valid}, 32'h0);
    ok = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (!(imem_req === 1'b1 && imem_addr === 32'h0 && instr_valid === 1'b0)) ok = 1'b0;
    end
    chk("gnt_withheld_stable", {31'h0, ok}, 32'h1);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    set_in(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0); tick();
    chk("late_gnt_pc", instr_pc, 32'h0);
    chk("late_gnt_ins", instruction, 32'h1234_5678);

    // ---- redirect while waiting: stale response dropped ----
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h103); tick();
    chk("redir_wait_state", {instr_valid, imem_req, 30'h0} | (imem_addr ^ 32'h100), 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    chk("redir_no_new_req", {31'h0, imem_req}, 32'h0);
    set_in(1'b0, 1'b1, 32'h57A1_E000, 1'b0, 32'h0); tick();
    chk("redir_stale_dropped", {30'h0, instr_valid, imem_req}, 32'h1);
    chk("redir_new_addr", imem_addr, 32'h100);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    set_in(1'b0, 1'b1, 32'h600D_0100, 1'b0, 32'h0); tick();
    chk("redir_first_pc", instr_pc, 32'h100);
    chk("redir_first_ins", instruction, 32'h600D_0100);

    // ---- redirect in REQ with same-cycle grant ----
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h41); tick();
    chk("redir_gnt_flush", {30'h0, instr_valid, imem_req}, 32'h0);
    set_in(1'b0, 1'b1, 32'hBAD0_0104, 1'b0, 32'h0); tick();
    chk("redir_gnt_dropped", {30'h0, instr_valid, imem_req}, 32'h1);
    chk("redir_gnt_addr", imem_addr, 32'h40);

    // ---- PC wrap ----
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE); tick();
    chk("wrap_addr_before", imem_addr, 32'hFFFF_FFFC);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0); tick();
    chk("wrap_addr_after", imem_addr, 32'h0);
    set_in(1'b0, 1'b1, 32'hF00D_0000, 1'b0, 32'h0); tick();
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);

    // ---- reset while waiting, response lands during/after reset ----
    do_reset();
    stall = 1'b1; auto_mem = 1'b1; imem_gnt = 1'b1;
    repeat (4) tick();
    chk("pre_reset_wait", {30'h0, instr_valid, imem_req}, 32'h2);
    auto_mem = 1'b0; rst = 1'b0;
    set_in(1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
    #1;
    chk("async_reset_out", {30'h0, instr_valid, imem_req} | imem_addr | instruction | instr_pc, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    stall = 1'b0;
    tick();
    chk("post_reset_idle", {30'h0, instr_valid, imem_req}, 32'h1);
    chk("post_reset_addr", imem_addr, 32'h0);
    got_pc.delete(); got_in.delete();
    imem_rvalid = 1'b0; auto_mem = 1'b1; imem_gnt = 1'b1;
    for (int n = 0; n < 10 && got_pc.size() < 1; n++) tick();
    chk("post_reset_count", got_pc.size(), 32'd1);
    if (got_pc.size() > 0) chk("post_reset_pc", got_pc[0], 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
